// File: rtl/mem_copy_engine.sv
// Word-granular memory copy engine: one read and one write cycle per word on the shared memory port.
// Optional running sum of copied words enabled by defining COPY_CHECKSUM_EN.
module mem_copy_engine #(
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      srcAddr,
    input  logic [31:0]      dstAddr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [31:0]      Address,
    output logic [31:0]      writeData,
    input  logic [31:0]      ReadData
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_buf;
    logic [LEN_W-1:0] r_cnt;
    logic             w_misaligned;
    logic             w_accept;

    assign w_misaligned = (srcAddr[1:0] != 2'b00) || (dstAddr[1:0] != 2'b00);
    assign w_accept     = (r_state == S_IDLE) && start && !w_misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = 32'd0;
        writeData = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_misaligned)            w_next = S_ERR;
                    else if (len == '0)          w_next = S_DONE;
                    else                         w_next = S_READ;
                end
            end
            S_READ: begin
                busy    = 1'b1;
                MemRead = 1'b1;
                Address = r_src;
                w_next  = S_WRITE;
            end
            S_WRITE: begin
                busy      = 1'b1;
                MemWrite  = 1'b1;
                Address   = r_dst;
                writeData = r_buf;
                w_next    = (r_cnt == LEN_W'(1)) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                done   = 1'b1;
                err    = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pointers advance after the write so a read always sees earlier writes (overlap replicates).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src <= 32'd0;
            r_dst <= 32'd0;
            r_buf <= 32'd0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_src <= srcAddr;
                r_dst <= dstAddr;
                r_cnt <= len;
            end
            if (r_state == S_READ) r_buf <= ReadData;
            if (r_state == S_WRITE) begin
                r_src <= r_src + 32'd4;
                r_dst <= r_dst + 32'd4;
                r_cnt <= r_cnt - LEN_W'(1);
            end
        end
    end

`ifdef COPY_CHECKSUM_EN
    logic [31:0] r_sum;

    // Rejected (misaligned) requests leave the previous sum visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   r_sum <= 32'd0;
        else if (w_accept)          r_sum <= 32'd0;
        else if (r_state == S_READ) r_sum <= r_sum + ReadData;
    end

    assign checksum = r_sum;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: queue-based cycle model of each request plus directed literal checks.
module tb_mem_copy_engine;
    localparam int LEN_W = 12;
    localparam int MW    = 4096;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      srcAddr = 32'd0;
    logic [31:0]      dstAddr = 32'd0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, err, MemRead, MemWrite;
    logic [31:0]      Address, writeData, ReadData;
`ifdef COPY_CHECKSUM_EN
    logic [31:0]      checksum;
`endif

    logic [31:0] mem  [MW];
    logic [31:0] rmem [MW];
    int vectors = 0;
    int miscompares = 0;

    mem_copy_engine #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .srcAddr(srcAddr), .dstAddr(dstAddr), .len(len),
        .busy(busy), .done(done), .err(err), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .writeData(writeData), .ReadData(ReadData)
`ifdef COPY_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    assign ReadData = mem[Address[13:2]];
    always @(posedge clk) if (MemWrite) mem[Address[13:2]] = writeData;

    function automatic int wi(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected per-cycle bus activity for the request in flight.
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        dn;
        logic        er;
        logic [31:0] a;
    } ent_t;

    function automatic ent_t mk(input logic rd, wr, dn, er, input logic [31:0] a);
        ent_t e;
        e.rd = rd; e.wr = wr; e.dn = dn; e.er = er; e.a = a;
        return e;
    endfunction

    ent_t        q[$];
    logic        cur_active = 1'b0;
    logic        pend_wr = 1'b0;
    logic        pend_rd = 1'b0;
    logic [31:0] pend_a = 32'd0;
    logic [31:0] pend_d = 32'd0;
    logic [31:0] exp_buf = 32'd0;
    logic [31:0] exp_ck = 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            if (pend_wr) rmem[wi(pend_a)] = pend_d;
            if (pend_rd) exp_ck = exp_ck + exp_buf;
            if (start && !cur_active && q.size() == 0) begin
                if (srcAddr[1:0] != 2'b00 || dstAddr[1:0] != 2'b00) begin
                    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'd0));
                end else begin
                    exp_ck = 32'd0;
                    for (int k = 0; k < int'(len); k++) begin
                        q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, srcAddr + 32'(4 * k)));
                        q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, dstAddr + 32'(4 * k)));
                    end
                    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
                end
            end
        end
        pend_wr = 1'b0;
        pend_rd = 1'b0;
    end

    ent_t ce;
    always @(negedge clk) begin
        ce = '0;
        if (!rst) begin
            q.delete();
            pend_wr = 1'b0;
            pend_rd = 1'b0;
            exp_ck  = 32'd0;
        end else if (q.size() > 0) begin
            ce = q.pop_front();
        end
        cur_active = ce.rd | ce.wr | ce.dn;
        if (ce.rd) begin
            exp_buf = rmem[wi(ce.a)];
            pend_rd = 1'b1;
        end
        chk("MemRead",   32'(MemRead),  32'(ce.rd));
        chk("MemWrite",  32'(MemWrite), 32'(ce.wr));
        chk("busy",      32'(busy),     32'(ce.rd | ce.wr));
        chk("done",      32'(done),     32'(ce.dn));
        chk("err",       32'(err),      32'(ce.er));
        chk("Address",   Address,       (ce.rd | ce.wr) ? ce.a : 32'd0);
        chk("writeData", writeData,     ce.wr ? exp_buf : 32'd0);
        chk("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
`ifdef COPY_CHECKSUM_EN
        chk("checksum",  checksum,      exp_ck);
`endif
        if (ce.wr) begin
            pend_wr = 1'b1;
            pend_a  = ce.a;
            pend_d  = exp_buf;
        end
    end

    task automatic setw(input int idx, input logic [31:0] v);
        mem[idx]  = v;
        rmem[idx] = v;
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input int l,
                       output int dc, output int bc, output int ac, output logic er);
        @(negedge clk); #1;
        start = 1'b1; srcAddr = s; dstAddr = d; len = LEN_W'(l);
        @(posedge clk); #1;
        start = 1'b0; srcAddr = $urandom; dstAddr = $urandom; len = LEN_W'($urandom);
        dc = -1; bc = 0; ac = 0; er = 1'b0;
        for (int c = 1; c <= 2 * l + 4; c++) begin
            @(negedge clk);
            if (busy) bc++;
            if (MemRead || MemWrite) ac++;
            if (done) begin
                dc = c;
                er = err;
                break;
            end
        end
        if (dc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL run_timeout: no done within %0d cycles", 2 * l + 4);
        end
    endtask

    initial begin
        int dc, bc, ac, ndiff, dones;
        logic er;
        logic [31:0] s1, d2old, rs, rd;
        int rl;
        logic mis;

        for (int i = 0; i < MW; i++) begin
            mem[i]  = $urandom;
            rmem[i] = mem[i];
        end
        @(negedge clk); #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done | err), 32'd0);
        chk("reset_bus",  32'(MemRead | MemWrite), 32'd0);
        chk("reset_addr", Address, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // Basic 3-word copy.
        setw(250, 32'h11); setw(251, 32'h22); setw(252, 32'h33);
        run(32'h3E8, 32'h7D0, 3, dc, bc, ac, er);
        chk("t1_done_cycle", 32'(dc), 32'd7);
        chk("t1_busy_cycles", 32'(bc), 32'd6);
        chk("t1_w500", mem[500], 32'h11);
        chk("t1_w501", mem[501], 32'h22);
        chk("t1_w502", mem[502], 32'h33);
`ifdef COPY_CHECKSUM_EN
        chk("t1_checksum", checksum, 32'h66);
`endif

        // Misaligned source is rejected without touching memory.
        run(32'h3E9, 32'h7D0, 2, dc, bc, ac, er);
        chk("t3_done_cycle", 32'(dc), 32'd1);
        chk("t3_err", 32'(er), 32'd1);
        chk("t3_busy_cycles", 32'(bc), 32'd0);
        chk("t3_accesses", 32'(ac), 32'd0);
`ifdef COPY_CHECKSUM_EN
        chk("t3_checksum_kept", checksum, 32'h66);
`endif

        // Zero-length request.
        run(32'h3E8, 32'h7D0, 0, dc, bc, ac, er);
        chk("t2_done_cycle", 32'(dc), 32'd1);
        chk("t2_err", 32'(er), 32'd0);
        chk("t2_accesses", 32'(ac), 32'd0);
        chk("t2_w500", mem[500], 32'h11);
`ifdef COPY_CHECKSUM_EN
        chk("t2_checksum", checksum, 32'd0);
`endif

        // Overlapping copy replicates the first word.
        setw(250, 32'hAB); setw(251, 32'hCD);
        run(32'h3E8, 32'h3EC, 2, dc, bc, ac, er);
        chk("t4_done_cycle", 32'(dc), 32'd5);
        chk("t4_w251", mem[251], 32'hAB);
        chk("t4_w252", mem[252], 32'hAB);

        // Reset during the write of word 2 of a 4-word copy.
        s1 = mem[64]; d2old = mem[577];
        @(negedge clk); #1;
        start = 1'b1; srcAddr = 32'h100; dstAddr = 32'h900; len = LEN_W'(4);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_bus", 32'(MemRead | MemWrite), 32'd0);
        chk("t5_async_addr", Address, 32'd0);
        chk("t5_async_wdata", writeData, 32'd0);
        chk("t5_async_done", 32'(done | err), 32'd0);
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        #1 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("t5_no_done", 32'(dones), 32'd0);
        chk("t5_word1", mem[576], s1);
        chk("t5_word2", mem[577], d2old);
        run(32'h100, 32'h900, 4, dc, bc, ac, er);
        chk("t5_restart_done", 32'(dc), 32'd9);
        chk("t5_restart_w4", mem[579], mem[67]);

        // start held high throughout a 2-word copy: only the first request runs.
        @(negedge clk); #1;
        start = 1'b1; srcAddr = 32'h200; dstAddr = 32'hA00; len = LEN_W'(2);
        dones = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c <= 5) begin
                srcAddr = {18'd0, 12'($urandom_range(1024, 2000)), 2'b00};
                dstAddr = {18'd0, 12'($urandom_range(2048, 3000)), 2'b00};
                len     = LEN_W'($urandom_range(1, 3));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) dones++;
        end
        chk("t6_done_pulses", 32'(dones), 32'd1);

        // Randomized requests; the cycle model checks every bus cycle.
        for (int it = 0; it < 40; it++) begin
            rs  = {18'd0, 12'($urandom_range(256, 4000)), 2'b00};
            rd  = {18'd0, 12'($urandom_range(256, 4000)), 2'b00};
            rl  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            mis = ($urandom_range(0, 7) == 0);
            if (mis) rs[1:0] = 2'($urandom_range(1, 3));
            run(rs, rd, rl, dc, bc, ac, er);
            chk("rnd_done_cycle", 32'(dc), (mis || rl == 0) ? 32'd1 : 32'(2 * rl + 1));
            chk("rnd_err", 32'(er), 32'(mis));
        end

        repeat (2) @(negedge clk);
        ndiff = 0;
        for (int i = 0; i < MW; i++) if (mem[i] !== rmem[i]) ndiff++;
        chk("mem_final", 32'(ndiff), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Word-granular copy engine that acts as a bus initiator on the unified instruction/data memory port (MemRead, MemWrite, Address, writeData, ReadData). Given a source byte address, a destination byte address and a word count, it alternates one read cycle and one write cycle per word until the block is copied, then pulses done. It sits beside the multicycle datapath and owns the memory port while busy; the top-level mux grants the port to the engine whenever busy is high.

## Interface
- LEN_W, 12: width of the word-count input; max transfer is 2^LEN_W − 1 words.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  request; sampled only in IDLE.
- srcAddr  input  32  source byte address; sampled with start.
- dstAddr  input  32  destination byte address; sampled with start.
- len  input  LEN_W  word count; sampled with start.
- busy  output  1  high in READ and WRITE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse, misaligned request rejected.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable; memory writes on the rising edge.
- Address  output  32  byte address to memory; the memory indexes with Address[31:2].
- writeData  output  32  write data to memory.
- ReadData  input  32  combinational read data from memory, valid in the same cycle as MemRead.
- checksum  output  32  present only with COPY_CHECKSUM_EN.

## Operation
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE: start=1 with srcAddr[1:0]≠0 or dstAddr[1:0]≠0 → ERR. Otherwise, if len=0 → DONE; else latch srcPtr, dstPtr and count=len → READ. start=0 → stay in IDLE.
- READ: MemRead=1, Address=srcPtr. At the edge, buffer←ReadData → WRITE.
- WRITE: MemWrite=1, Address=dstPtr, writeData=buffer. At the edge, srcPtr+=4, dstPtr+=4, count−=1. If count was 1 → DONE; else → READ.
- DONE: done=1, go to IDLE. ERR: err=1 and done=1, go to IDLE. No memory access is made on an error.
- MemRead and MemWrite are never both high. In IDLE, DONE and ERR: Address=0, writeData=0, MemRead=0, MemWrite=0.
- Pointers wrap modulo 2^32. No range check is made against the memory depth.
- Copies run in ascending order with no overlap protection. dstAddr=srcAddr+4 replicates the first source word across the whole destination.
- start is ignored outside IDLE. Inputs may change freely after the accepting edge.
- Reset value of every output is 0, and state returns to IDLE. A reset mid-copy abandons the transfer: words already written stay written, and no done is raised.

## Timing
- Accepting edge E0. Word k (1-based) is read in the cycle after E(2k−2) and written at edge E(2k).
- done is high in the cycle after E(2·len). For len=0, that is the cycle right after E0.
- Throughput is 2 cycles per word. The next start is accepted one cycle after done.
- busy rises the cycle after E0 and falls in the DONE cycle.

## Configuration
- COPY_CHECKSUM_EN defined:
  - checksum port exists, cleared to 0 on reset and on every accepted start (including len=0).
  - In each READ cycle, checksum += ReadData, modulo 2^32.
  - checksum is held after done until the next accepted start. It is not cleared on err.
- COPY_CHECKSUM_EN undefined: no checksum port and no adder. All other behaviour is identical.

## Test plan
- Memory words 250..252 = 0x11, 0x22, 0x33; start with src=0x3E8, dst=0x7D0, len=3 → words 500..502 = 0x11, 0x22, 0x33; done in cycle 7 after E0; busy high for 6 cycles; checksum=0x66 when enabled.
- len=0, src=0x3E8, dst=0x7D0 → done in cycle 1 after E0, no MemRead/MemWrite, memory unchanged, checksum=0.
- src=0x3E9 (misaligned), len=2 → err=1 and done=1 in cycle 1, no memory access, busy stays 0.
- Overlap: word 250=0xAB, word 251=0xCD, src=0x3E8, dst=0x3EC, len=2 → words 251 and 252 both = 0xAB.
- rst driven low during the WRITE of word 2 of a 4-word copy → all outputs 0 asynchronously, word 1 copied, word 2 unwritten, no done; a fresh start after release completes normally.
- start pulsed every cycle during a 2-word copy → only the first request executes; exactly one done pulse; MemRead & MemWrite never high together.
